// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU that decodes the 4-bit ALUctrl code.
// Single-cycle ops give a registered result one cycle after accept. MUL is an
// iterative shift-add that runs for DATA_W cycles. valid/ready on both sides.
module alu_exec_unit #(
    parameter int DATA_W = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [3:0]        ALUctrl_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              overflow_o,
    output logic              illegal_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int MSB   = DATA_W - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic              ovf_q, ovf_d;
    logic              ill_q, ill_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              accept;
    logic [DATA_W-1:0] sum, diff, acc_step, alu_res;
    logic              add_ovf, sub_ovf, slt, alu_ovf, alu_ill, is_mul;

    assign ready_o = (state_q == S_IDLE) | ((state_q == S_DONE) & ready_i);
    assign accept  = valid_i & ready_o;

    assign sum     = src1_i + src2_i;
    assign diff    = src1_i - src2_i;
    assign add_ovf = (src1_i[MSB] == src2_i[MSB]) & (sum[MSB] != src1_i[MSB]);
    assign sub_ovf = (src1_i[MSB] != src2_i[MSB]) & (diff[MSB] != src1_i[MSB]);
    // Sign of A-B corrected by its overflow gives a signed less-than valid at the extremes.
    assign slt     = diff[MSB] ^ sub_ovf;

    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Decode the control code into a single-cycle result, or flag MUL.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        is_mul  = 1'b0;
        case (ALUctrl_i)
            4'b0000: alu_res = src1_i & src2_i;
            4'b0001: alu_res = src1_i | src2_i;
            4'b0010: begin
                alu_res = sum;
                alu_ovf = add_ovf;
            end
            4'b0110: begin
                alu_res = diff;
                alu_ovf = sub_ovf;
            end
            4'b0111: alu_res = {{(DATA_W-1){1'b0}}, slt};
            4'b1100: alu_res = ~(src1_i | src2_i);
            4'b1000: begin
                if (MUL_EN) is_mul = 1'b1;
                else        alu_ill = 1'b1;
            end
            default: alu_ill = 1'b1;
        endcase
    end

    // Next-state: MUL iteration, DONE retirement, then accept overrides.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        ill_d    = ill_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: ;
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // The final iteration's sum is loaded straight into the result.
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d  = S_DONE;
                    result_d = acc_step;
                    zero_d   = (acc_step == '0);
                    ovf_d    = 1'b0;
                    ill_d    = 1'b0;
                end
            end
            S_DONE: begin
                if (ready_i && !valid_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            if (is_mul) begin
                state_d  = S_MUL;
                mcand_d  = src1_i;
                mplier_d = src2_i;
                acc_d    = '0;
                cnt_d    = '0;
            end else begin
                state_d  = S_DONE;
                result_d = alu_res;
                zero_d   = (alu_res == '0);
                ovf_d    = alu_ovf;
                ill_d    = alu_ill;
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign valid_o    = (state_q == S_DONE);
    assign result_o   = result_q;
    assign zero_o     = zero_q;
    assign overflow_o = ovf_q;
    assign illegal_o  = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit: directed vector table, corner sequences
// (backpressure, back-to-back, reset mid-MUL, MUL_EN=0) and random ops
// checked against an arithmetic reference model.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst, valid_i, ready_i, valid2_i;
    logic [3:0]  ctrl;
    logic [31:0] a, b;
    logic        ready_o, valid_o, zero_o, ovf_o, ill_o;
    logic [31:0] result_o;
    logic        ready2_o, valid2_o, zero2_o, ovf2_o, ill2_o;
    logic [31:0] result2_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.DATA_W(32), .MUL_EN(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
        .ALUctrl_i(ctrl), .src1_i(a), .src2_i(b), .valid_o(valid_o),
        .ready_i(ready_i), .result_o(result_o), .zero_o(zero_o),
        .overflow_o(ovf_o), .illegal_o(ill_o)
    );

    alu_exec_unit #(.DATA_W(32), .MUL_EN(1'b0)) dut_nomul (
        .clk_i(clk), .rst_i(rst), .valid_i(valid2_i), .ready_o(ready2_o),
        .ALUctrl_i(ctrl), .src1_i(a), .src2_i(b), .valid_o(valid2_o),
        .ready_i(1'b1), .result_o(result2_o), .zero_o(zero2_o),
        .overflow_o(ovf2_o), .illegal_o(ill2_o)
    );

    typedef struct {
        logic [3:0]  c;
        logic [31:0] x, y, res;
        bit          ov, il;
        int          lat;
        string       name;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain signed/unsigned arithmetic on 64-bit integers.
    task automatic model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output bit ov, output bit il, output int lat);
        longint sx, sy, s;
        logic [63:0] p;
        sx  = $signed(x);
        sy  = $signed(y);
        r   = '0;
        ov  = 0;
        il  = 0;
        lat = 1;
        case (c)
            4'd0:  r = x & y;
            4'd1:  r = x | y;
            4'd2:  begin s = sx + sy; r = 32'(s); ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd6:  begin s = sx - sy; r = 32'(s); ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd7:  r = (sx < sy) ? 32'd1 : 32'd0;
            4'd12: r = ~(x | y);
            4'd8:  begin p = {32'b0, x} * {32'b0, y}; r = p[31:0]; lat = 33; end
            default: il = 1;
        endcase
    endtask

    // Issue one op from IDLE with ready_i=1, wait for the result, check it, let it retire.
    task automatic run_op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] er, input bit eo, input bit ei, input int elat,
                          input string tag);
        int lat;
        bit busy_ok;
        ctrl    = c;
        a       = x;
        b       = y;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        ctrl    = 4'($urandom);
        a       = $urandom;
        b       = $urandom;
        lat     = 1;
        busy_ok = 1;
        while (!valid_o && lat < 60) begin
            if (ready_o) busy_ok = 0;
            tick();
            lat++;
        end
        chk({tag, " valid_o"}, 32'(valid_o), 32'd1);
        chk({tag, " latency"}, lat, elat);
        chk({tag, " result"}, result_o, er);
        chk({tag, " zero"}, 32'(zero_o), 32'(er == 32'd0));
        chk({tag, " overflow"}, 32'(ovf_o), 32'(eo));
        chk({tag, " illegal"}, 32'(ill_o), 32'(ei));
        if (elat > 1) chk({tag, " ready_o low while busy"}, 32'(busy_ok), 32'd1);
        tick();
        chk({tag, " retire"}, 32'(valid_o), 32'd0);
    endtask

    initial begin
        vec_t        vecs[$];
        logic [3:0]  codes[8];
        logic [31:0] er;
        bit          eo, ei, stable, seen;
        int          el;
        logic [3:0]  rc;
        logic [31:0] rx, ry;

        rst = 1'b1; valid_i = 1'b0; valid2_i = 1'b0; ready_i = 1'b1;
        ctrl = '0; a = '0; b = '0;
        tick();
        tick();
        chk("reset valid_o", 32'(valid_o), 32'd0);
        chk("reset ready_o", 32'(ready_o), 32'd1);
        chk("reset result", result_o, 32'd0);
        chk("reset zero", 32'(zero_o), 32'd0);
        chk("reset ovf/ill", {30'd0, ovf_o, ill_o}, 32'd0);
        rst = 1'b0;
        tick();

        vecs.push_back('{4'b0010, 32'd5, 32'd3, 32'd8, 0, 0, 1, "ADD 5+3"});
        vecs.push_back('{4'b0110, 32'd5, 32'd5, 32'd0, 0, 0, 1, "SUB 5-5"});
        vecs.push_back('{4'b0000, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 0, 0, 1, "AND"});
        vecs.push_back('{4'b0001, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 0, 0, 1, "OR"});
        vecs.push_back('{4'b1100, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 0, 1, "NOR 0,0"});
        vecs.push_back('{4'b0010, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1, 0, 1, "ADD ovf"});
        vecs.push_back('{4'b0110, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1, 0, 1, "SUB ovf"});
        vecs.push_back('{4'b0010, 32'hFFFFFFFF, 32'd1, 32'h0, 0, 0, 1, "ADD wrap no ovf"});
        vecs.push_back('{4'b0111, 32'h80000000, 32'h7FFFFFFF, 32'd1, 0, 0, 1, "SLT min<max"});
        vecs.push_back('{4'b0111, 32'd5, 32'hFFFFFFFF, 32'd0, 0, 0, 1, "SLT 5<-1"});
        vecs.push_back('{4'b0111, 32'd3, 32'd3, 32'd0, 0, 0, 1, "SLT equal"});
        vecs.push_back('{4'b1000, 32'h00010003, 32'h00000005, 32'h0005000F, 0, 0, 33, "MUL small"});
        vecs.push_back('{4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, 0, 33, "MUL max"});
        vecs.push_back('{4'b0011, 32'd12, 32'd34, 32'd0, 0, 1, 1, "ILLEGAL 0011"});
        vecs.push_back('{4'b1111, 32'd1, 32'd1, 32'd0, 0, 1, 1, "ILLEGAL 1111"});

        foreach (vecs[i])
            run_op(vecs[i].c, vecs[i].x, vecs[i].y, vecs[i].res, vecs[i].ov, vecs[i].il,
                   vecs[i].lat, vecs[i].name);

        // MUL_EN=0 instance: code 1000 is illegal, ADD still works.
        ctrl = 4'b1000; a = 32'd3; b = 32'd4; valid2_i = 1'b1;
        tick();
        valid2_i = 1'b0;
        chk("nomul valid_o", 32'(valid2_o), 32'd1);
        chk("nomul illegal", 32'(ill2_o), 32'd1);
        chk("nomul result", result2_o, 32'd0);
        chk("nomul zero", 32'(zero2_o), 32'd1);
        tick();
        ctrl = 4'b0010; a = 32'd3; b = 32'd4; valid2_i = 1'b1;
        tick();
        valid2_i = 1'b0;
        chk("nomul ADD result", result2_o, 32'd7);
        chk("nomul ADD illegal", 32'(ill2_o), 32'd0);
        tick();

        // Backpressure then back-to-back.
        ready_i = 1'b0;
        ctrl = 4'b0010; a = 32'd10; b = 32'd20; valid_i = 1'b1;
        tick();
        chk("bp ADD result", result_o, 32'd30);
        stable = 1;
        ctrl = 4'b0010; a = 32'd111; b = 32'd222;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!valid_o || result_o != 32'd30 || zero_o || ovf_o || ill_o || ready_o) stable = 0;
        end
        chk("bp outputs stable", 32'(stable), 32'd1);
        ready_i = 1'b1;
        ctrl = 4'b0110; a = 32'd9; b = 32'd4; valid_i = 1'b1;
        #1;
        chk("b2b ready_o", 32'(ready_o), 32'd1);
        tick();
        valid_i = 1'b0;
        chk("b2b valid_o", 32'(valid_o), 32'd1);
        chk("b2b SUB result", result_o, 32'd5);
        tick();
        chk("b2b retire", 32'(valid_o), 32'd0);

        // Reset in the middle of a MUL: the result must never appear.
        ctrl = 4'b1000; a = 32'd7; b = 32'd9; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst-mul valid_o", 32'(valid_o), 32'd0);
        chk("rst-mul ready_o", 32'(ready_o), 32'd1);
        chk("rst-mul result", result_o, 32'd0);
        seen = 0;
        repeat (40) begin
            tick();
            if (valid_o) seen = 1;
        end
        chk("rst-mul no result", 32'(seen), 32'd0);

        // Random ops against the reference model.
        codes = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd8, 4'd0};
        for (int n = 0; n < 150; n++) begin
            rc = codes[$urandom_range(0, 6)];
            if ($urandom_range(0, 7) == 0) rc = 4'($urandom);
            case ($urandom_range(0, 3))
                0: rx = 32'h80000000;
                1: rx = 32'h7FFFFFFF;
                default: rx = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: ry = 32'h80000000;
                1: ry = 32'hFFFFFFFF;
                default: ry = $urandom;
            endcase
            model(rc, rx, ry, er, eo, ei, el);
            run_op(rc, rx, ry, er, eo, ei, el, $sformatf("rand%0d op%h", n, rc));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
